// File: rtl/bp_det_pkg.sv
// Shared definitions for the band power detector: FSM state codes, default
// accumulator width and the width-generic saturating add.
package bp_det_pkg;

  localparam int ACC_W_DEF = 64;
  // Wide enough to hold any ACC_W up to SAT_W-1 plus a carry.
  localparam int SAT_W     = 128;

  localparam logic [1:0] ST_QUIET  = 2'd0;
  localparam logic [1:0] ST_ARMING = 2'd1;
  localparam logic [1:0] ST_ALARM  = 2'd2;

  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] b,
                                               input logic [SAT_W-1:0] lim);
    logic [SAT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, lim}) ? lim : s[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/band_power_detector_sq_accum.sv
// Square / shift / saturating-accumulate datapath with valid-sample window
// counter; emits the final window sum with a one-cycle done strobe.
module sq_accum
  import bp_det_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int WIN_LEN  = 1024,
  parameter int SQ_SHIFT = 16,
  parameter int ACC_W    = ACC_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] i_y,
  input  logic                     i_y_valid,
  output logic [ACC_W-1:0]         o_win_sum,
  output logic                     o_win_done
);

  localparam int SQ_W  = 2 * DATA_W;
  localparam int CNT_W = $clog2(WIN_LEN);
  localparam logic [SAT_W-1:0] ACC_MAX = SAT_W'({ACC_W{1'b1}});
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN_LEN - 1);

  logic signed [DATA_W-1:0] r_y_p1;
  logic                     r_vld_p1;
  logic [SQ_W-1:0]          r_term_p2;
  logic                     r_vld_p2;
  logic [ACC_W-1:0]         r_acc_p3;
  logic [ACC_W-1:0]         r_sum_p3;
  logic                     r_done_p3;
  logic [CNT_W-1:0]         r_cnt_p3;

  logic signed [SQ_W-1:0]   w_y_ext;
  logic signed [SQ_W-1:0]   w_sq;
  logic [SQ_W-1:0]          w_sq_u;
  logic [ACC_W-1:0]         w_acc_next;

  // Full-width square: (-2^(DATA_W-1))^2 still fits as a positive value.
  assign w_y_ext    = SQ_W'(r_y_p1);
  assign w_sq       = w_y_ext * w_y_ext;
  assign w_sq_u     = w_sq;
  assign w_acc_next = ACC_W'(sat_add(SAT_W'(r_acc_p3), SAT_W'(r_term_p2), ACC_MAX));

  // S1 capture, S2 square and shift
  always_ff @(posedge clk) begin
    r_y_p1    <= i_y;
    r_term_p2 <= w_sq_u >> SQ_SHIFT;
  end

  // S3 accumulate; the closing term goes into the reported sum while the
  // accumulator restarts empty for the next window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_p1  <= 1'b0;
      r_vld_p2  <= 1'b0;
      r_acc_p3  <= '0;
      r_sum_p3  <= '0;
      r_done_p3 <= 1'b0;
      r_cnt_p3  <= '0;
    end else begin
      r_vld_p1  <= i_y_valid;
      r_vld_p2  <= r_vld_p1;
      r_done_p3 <= 1'b0;
      if (r_vld_p2) begin
        if (r_cnt_p3 == CNT_LAST) begin
          r_sum_p3  <= w_acc_next;
          r_acc_p3  <= '0;
          r_cnt_p3  <= '0;
          r_done_p3 <= 1'b1;
        end else begin
          r_acc_p3 <= w_acc_next;
          r_cnt_p3 <= r_cnt_p3 + 1'b1;
        end
      end
    end
  end

  assign o_win_sum  = r_sum_p3;
  assign o_win_done = r_done_p3;

endmodule

// File: rtl/band_power_detector.sv
// Windowed band energy detector with consecutive-hit alarm FSM.
// Optional BAND_POWER_HYST_EN adds thresh_lo for alarm-release hysteresis.
module band_power_detector
  import bp_det_pkg::*;
#(
  parameter int WIN_LEN  = 1024,
  parameter int SQ_SHIFT = 16,
  parameter int ACC_W    = ACC_W_DEF,
  parameter int DET_CNT  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [31:0] y,
  input  logic               y_valid,
  input  logic [ACC_W-1:0]   thresh,
`ifdef BAND_POWER_HYST_EN
  input  logic [ACC_W-1:0]   thresh_lo,
`endif
  output logic [ACC_W-1:0]   energy,
  output logic               energy_valid,
  output logic               detect,
  output logic [15:0]        win_idx
);

  localparam int HITS_W = $clog2(DET_CNT + 1);

  logic [ACC_W-1:0]  w_win_sum;
  logic              w_win_done;
  logic              w_hit;
  logic              w_clear;
  logic [HITS_W-1:0] w_hits_inc;

  logic [1:0]        r_state;
  logic [HITS_W-1:0] r_hits;
  logic [ACC_W-1:0]  r_energy;
  logic              r_energy_valid;
  logic              r_detect;
  logic [15:0]       r_win_idx;

  sq_accum #(
    .DATA_W   (32),
    .WIN_LEN  (WIN_LEN),
    .SQ_SHIFT (SQ_SHIFT),
    .ACC_W    (ACC_W)
  ) u_sq_accum (
    .clk        (clk),
    .reset      (reset),
    .i_y        (y),
    .i_y_valid  (y_valid),
    .o_win_sum  (w_win_sum),
    .o_win_done (w_win_done)
  );

  assign w_hit      = w_win_sum > thresh;
  assign w_hits_inc = r_hits + 1'b1;
`ifdef BAND_POWER_HYST_EN
  assign w_clear = w_win_sum < thresh_lo;
`else
  assign w_clear = !w_hit;
`endif

  // Output stage: energy, strobe and detect all move on the window-done edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_QUIET;
      r_hits         <= '0;
      r_energy       <= '0;
      r_energy_valid <= 1'b0;
      r_detect       <= 1'b0;
      r_win_idx      <= '0;
    end else begin
      r_energy_valid <= w_win_done;
      if (w_win_done) begin
        r_energy  <= w_win_sum;
        r_win_idx <= r_win_idx + 1'b1;
        case (r_state)
          ST_QUIET: begin
            if (w_hit) begin
              r_hits <= HITS_W'(1);
              if (DET_CNT == 1) begin
                r_state  <= ST_ALARM;
                r_detect <= 1'b1;
              end else begin
                r_state <= ST_ARMING;
              end
            end
          end
          ST_ARMING: begin
            if (w_hit) begin
              r_hits <= w_hits_inc;
              if (w_hits_inc == HITS_W'(DET_CNT)) begin
                r_state  <= ST_ALARM;
                r_detect <= 1'b1;
              end
            end else begin
              r_state <= ST_QUIET;
              r_hits  <= '0;
            end
          end
          ST_ALARM: begin
            if (w_clear) begin
              r_state  <= ST_QUIET;
              r_hits   <= '0;
              r_detect <= 1'b0;
            end
          end
          default: begin
            r_state  <= ST_QUIET;
            r_hits   <= '0;
            r_detect <= 1'b0;
          end
        endcase
      end
    end
  end

  assign energy       = r_energy;
  assign energy_valid = r_energy_valid;
  assign detect       = r_detect;
  assign win_idx      = r_win_idx;

endmodule

// File: tb/tb_band_power_detector.sv
// Randomised self-checking bench for band_power_detector against a
// window-level energy / consecutive-hit model.
module tb_band_power_detector;

  localparam int WIN_LEN  = 16;
  localparam int SQ_SHIFT = 0;
  localparam int DET_CNT  = 3;
  localparam int ACC_W    = 64;

  logic               clk;
  logic               reset;
  logic signed [31:0] y;
  logic               y_valid;
  logic [ACC_W-1:0]   thresh;
  logic [ACC_W-1:0]   thresh_lo;
  logic [ACC_W-1:0]   energy;
  logic               energy_valid;
  logic               detect;
  logic [15:0]        win_idx;

  band_power_detector #(
    .WIN_LEN  (WIN_LEN),
    .SQ_SHIFT (SQ_SHIFT),
    .ACC_W    (ACC_W),
    .DET_CNT  (DET_CNT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .y            (y),
    .y_valid      (y_valid),
    .thresh       (thresh),
`ifdef BAND_POWER_HYST_EN
    .thresh_lo    (thresh_lo),
`endif
    .energy       (energy),
    .energy_valid (energy_valid),
    .detect       (detect),
    .win_idx      (win_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          due;
    logic [63:0] energy;
    bit          det;
    logic [15:0] widx;
  } exp_t;
  exp_t q[$];

  logic [127:0] m_sum;
  int           m_cnt;
  int           m_consec;
  bit           m_det;
  logic [15:0]  m_widx;
  logic [63:0]  cur_energy;
  bit           cur_det;
  logic [15:0]  cur_widx;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    m_sum = '0; m_cnt = 0; m_consec = 0; m_det = 0; m_widx = '0;
    cur_energy = '0; cur_det = 0; cur_widx = '0;
    q.delete();
  endtask

  // Window-level view: energy = min(sum of squares, 2^64-1); alarm after
  // DET_CNT consecutive hits, released by the clear rule.
  task automatic model_sample(input logic signed [31:0] yv);
    longint       sq;
    logic [63:0]  e;
    bit           hit, clr;
    exp_t         ev;
    sq = longint'(yv) * longint'(yv);
    m_sum += 128'(64'(sq) >> SQ_SHIFT);
    m_cnt++;
    if (m_cnt == WIN_LEN) begin
      e = (m_sum > 128'({64{1'b1}})) ? {64{1'b1}} : m_sum[63:0];
      hit = e > thresh;
`ifdef BAND_POWER_HYST_EN
      clr = e < thresh_lo;
`else
      clr = !hit;
`endif
      if (!m_det) begin
        m_consec = hit ? m_consec + 1 : 0;
        if (m_consec >= DET_CNT) m_det = 1;
      end else if (clr) begin
        m_det = 0;
        m_consec = 0;
      end
      m_widx++;
      ev.due = cyc + 4; ev.energy = e; ev.det = m_det; ev.widx = m_widx;
      q.push_back(ev);
      m_sum = '0;
      m_cnt = 0;
    end
  endtask

  task automatic check_outputs();
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("energy_valid", 64'(energy_valid), 64'd1);
      chk("energy", energy, q[0].energy);
      chk("detect", 64'(detect), 64'(q[0].det));
      chk("win_idx", 64'(win_idx), 64'(q[0].widx));
      cur_energy = q[0].energy;
      cur_det = q[0].det;
      cur_widx = q[0].widx;
      void'(q.pop_front());
    end else begin
      chk("energy_valid_idle", 64'(energy_valid), 64'd0);
      chk("energy_hold", energy, cur_energy);
      chk("detect_hold", 64'(detect), 64'(cur_det));
      chk("win_idx_hold", 64'(win_idx), 64'(cur_widx));
    end
  endtask

  task automatic step(input logic signed [31:0] yv, input bit v);
    @(negedge clk);
    check_outputs();
    y = yv;
    y_valid = v;
    if (v) model_sample(yv);
  endtask

  task automatic windows(input logic signed [31:0] yv, input int n);
    for (int i = 0; i < n * WIN_LEN; i++) step(yv, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(32'sd0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    check_outputs();
    y_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_energy", energy, 64'd0);
    chk("rst_energy_valid", 64'(energy_valid), 64'd0);
    chk("rst_detect", 64'(detect), 64'd0);
    chk("rst_win_idx", 64'(win_idx), 64'd0);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; y = '0; y_valid = 1'b0;
    thresh = 64'd15_999_999;
    thresh_lo = 64'd8_000_000;
    model_clear();
    @(negedge clk);
    chk("init_energy", energy, 64'd0);
    chk("init_energy_valid", 64'(energy_valid), 64'd0);
    chk("init_detect", 64'(detect), 64'd0);
    chk("init_win_idx", 64'(win_idx), 64'd0);
    reset = 1'b0;

    // constant +1000: detect on third window
    windows(32'sd1000, 3);
    idle(6);
    do_reset();
    // constant -1000: same energies
    windows(-32'sd1000, 3);
    idle(6);
    // most negative input saturates every window
    windows(32'sh8000_0000, 2);
    idle(6);
    // half-rate valid, y=10
    for (int i = 0; i < 2 * WIN_LEN; i++) begin
      step(32'sd10, 1'b1);
      step(32'sd99, 1'b0);
    end
    idle(6);
    // alarm, then mid-level window, then silent window
    do_reset();
    windows(32'sd1000, 3);
    windows(32'sd800, 1);
    windows(32'sd0, 1);
    idle(6);
    // reset mid-window, then a fresh full window
    for (int i = 0; i < 9; i++) step(32'sd1000, 1'b1);
    do_reset();
    windows(32'sd1000, 1);
    idle(6);
    // randomised amplitudes and valid gaps
    for (int w = 0; w < 12; w++) begin
      int amp;
      int k;
      case ($urandom_range(0, 3))
        0: amp = 100;
        1: amp = 2000;
        2: amp = 30000;
        default: amp = 2147483647;
      endcase
      k = 0;
      while (k < WIN_LEN) begin
        bit v;
        logic signed [31:0] yv;
        v = ($urandom_range(0, 3) != 0);
        yv = 32'($urandom_range(0, 2 * amp)) - 32'(amp);
        if (amp == 2147483647) yv = $urandom;
        step(yv, v);
        if (v) k++;
      end
    end
    idle(8);
    chk("pending_events", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1);
  end

endmodule
